cpu_core_param: RTL and testbench

Parametrised successor to the nibble CPU core: a single-accumulator processor with `2**AW` program and data words, selectable jump conditions, carry/zero flags, free-running execution, self-jump halt detection and an executed-instruction counter. It sits between the `io_in`/`io_out` pin mapping in the top module and the RP2040 host. The host loads program and data words, sets the start PC, then single-steps or free-runs the program.

---
 rtl/cpu_core_pkg.sv | 43 ++++
 rtl/cpu_alu.sv | 80 ++++++++
 rtl/cpu_core_param.sv | 178 +++++++++++++++++
 tb/tb_cpu_core_param.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_core_pkg.sv
// -----------------------------------------------------------------------------
// cpu_core_pkg
// Shared encodings for the parametrised accumulator CPU core:
//   opcode_e : 4-bit instruction opcodes (0..15)
//   mode_e   : host operating modes driven on the 2-bit `mode` port
//   cond_e   : JUMPTOIF condition selects driven on the 2-bit `cond_sel` port
// -----------------------------------------------------------------------------
package cpu_core_pkg;

  typedef enum logic [3:0] {
    OP_LOAD     = 4'd0,
    OP_STORE    = 4'd1,
    OP_ADD      = 4'd2,
    OP_MUL      = 4'd3,
    OP_SUB      = 4'd4,
    OP_SHIFTL   = 4'd5,
    OP_SHIFTR   = 4'd6,
    OP_JUMPTOIF = 4'd7,
    OP_LOGICAND = 4'd8,
    OP_LOGICOR  = 4'd9,
    OP_EQ       = 4'd10,
    OP_NEQ      = 4'd11,
    OP_BITAND   = 4'd12,
    OP_BITOR    = 4'd13,
    OP_LOGICNOT = 4'd14,
    OP_BITNOT   = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    LOADPROG = 2'd0,
    LOADDATA = 2'd1,
    SETRUNPT = 2'd2,
    RUNPROG  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    COND_EXT    = 2'd0,
    COND_C      = 2'd1,
    COND_Z      = 2'd2,
    COND_ALWAYS = 2'd3
  } cond_e;

endpackage

// File: rtl/cpu_alu.sv
// -----------------------------------------------------------------------------
// cpu_alu
// Purely combinational ALU for the accumulator CPU.
// Ports:
//   op     in  opcode_e : current instruction
//   regval in  DW       : accumulator value
//   opd    in  DW       : operand word (data memory at the PC)
//   result out DW       : new accumulator value (valid when wr_reg)
//   carry  out 1        : new carry flag (valid when wr_c)
//   wr_reg out 1        : opcode updates the accumulator
//   wr_c   out 1        : opcode updates the carry flag (ADD, SUB, MUL)
// -----------------------------------------------------------------------------
import cpu_core_pkg::*;

module cpu_alu #(
  parameter int DW = 4
) (
  input  opcode_e       op,
  input  logic [DW-1:0] regval,
  input  logic [DW-1:0] opd,
  output logic [DW-1:0] result,
  output logic          carry,
  output logic          wr_reg,
  output logic          wr_c
);

  // Largest meaningful shift distance; anything bigger is clamped to it.
  localparam logic [DW-1:0] SH_MAX = DW'(DW - 1);

  logic [DW:0]     sum;
  logic [DW:0]     diff;
  logic [2*DW-1:0] prod;
  logic [DW-1:0]   sh;

  always_comb begin
    sum    = {1'b0, regval} + {1'b0, opd};
    // The extra MSB of a zero-extended subtraction is the borrow.
    diff   = {1'b0, regval} - {1'b0, opd};
    prod   = {{DW{1'b0}}, regval} * {{DW{1'b0}}, opd};
    sh     = (opd > SH_MAX) ? SH_MAX : opd;

    result = regval;
    carry  = 1'b0;
    wr_reg = 1'b1;
    wr_c   = 1'b0;

    case (op)
      OP_LOAD:     result = opd;
      OP_STORE:    wr_reg = 1'b0;
      OP_ADD: begin
        result = sum[DW-1:0];
        carry  = sum[DW];
        wr_c   = 1'b1;
      end
      OP_SUB: begin
        result = diff[DW-1:0];
        carry  = diff[DW];
        wr_c   = 1'b1;
      end
      OP_MUL: begin
        result = prod[DW-1:0];
        carry  = |prod[2*DW-1:DW];
        wr_c   = 1'b1;
      end
      OP_SHIFTL:   result = regval << sh;
      OP_SHIFTR:   result = regval >> sh;
      OP_JUMPTOIF: wr_reg = 1'b0;
      OP_LOGICAND: result = {{(DW-1){1'b0}}, (|regval) & (|opd)};
      OP_LOGICOR:  result = {{(DW-1){1'b0}}, (|regval) | (|opd)};
      OP_EQ:       result = {{(DW-1){1'b0}}, regval == opd};
      OP_NEQ:      result = {{(DW-1){1'b0}}, regval != opd};
      OP_BITAND:   result = regval & opd;
      OP_BITOR:    result = regval | opd;
      OP_LOGICNOT: result = {{(DW-1){1'b0}}, regval == '0};
      OP_BITNOT:   result = ~regval;
      default:     wr_reg = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_core_param.sv
// -----------------------------------------------------------------------------
// cpu_core_param
// Single-accumulator CPU with 2**AW program words (4 bit) and 2**AW data
// words (DW bit). The host loads program/data, sets the start PC, then
// single-steps (i_step) or free-runs (i_run in RUNPROG mode).
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   i_step               : one-cycle action strobe for the current mode
//   i_run                : free-run level, effective only in RUNPROG
//   mode [1:0]           : LOADPROG / LOADDATA / SETRUNPT / RUNPROG
//   data_in [DW-1:0]     : host write data / opcode / start PC
//   cond_ext, cond_sel   : JUMPTOIF condition source and select
//   pc, regval, c_flag   : registered architectural state
//   z_flag               : combinational regval == 0
//   halted               : taken self-jump has stopped execution
//   icount [CW-1:0]      : saturating executed-instruction counter
// -----------------------------------------------------------------------------
import cpu_core_pkg::*;

module cpu_core_param #(
  parameter int DW = 4,
  parameter int AW = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_step,
  input  logic          i_run,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] data_in,
  input  logic          cond_ext,
  input  logic [1:0]    cond_sel,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] regval,
  output logic          c_flag,
  output logic          z_flag,
  output logic          halted,
  output logic [CW-1:0] icount
);

  localparam int DEPTH = 2**AW;
  // Common width wide enough to slice an opcode (4 bits) or an address (AW
  // bits) out of a DW-bit word, even when DW is narrower than either.
  localparam int XW0 = (DW > AW) ? DW : AW;
  localparam int XW  = (XW0 > 4) ? XW0 : 4;

  logic [3:0]    prog_q [DEPTH];
  logic [3:0]    prog_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] regval_q, regval_d;
  logic          c_q, c_d;
  logic          halted_q, halted_d;
  logic [CW-1:0] icount_q, icount_d;

  logic          act;
  opcode_e       op;
  logic [DW-1:0] opd;
  logic [XW-1:0] din_x;
  logic [XW-1:0] opd_x;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] target;
  logic          cond_true;
  logic [DW-1:0] alu_result;
  logic          alu_carry;
  logic          alu_wr_reg;
  logic          alu_wr_c;

  assign act    = i_step | (i_run & (mode == RUNPROG));
  assign op     = opcode_e'(prog_q[pc_q]);
  assign opd    = data_q[pc_q];
  assign din_x  = XW'(data_in);
  assign opd_x  = XW'(opd);
  assign pc_inc = pc_q + AW'(1);
  assign target = opd_x[AW-1:0];

  cpu_alu #(.DW(DW)) u_alu (
    .op     (op),
    .regval (regval_q),
    .opd    (opd),
    .result (alu_result),
    .carry  (alu_carry),
    .wr_reg (alu_wr_reg),
    .wr_c   (alu_wr_c)
  );

  always_comb begin
    cond_true = 1'b0;
    case (cond_e'(cond_sel))
      COND_EXT:    cond_true = cond_ext;
      COND_C:      cond_true = c_q;
      COND_Z:      cond_true = (regval_q == '0);
      COND_ALWAYS: cond_true = 1'b1;
      default:     cond_true = 1'b0;
    endcase
  end

  always_comb begin
    prog_d   = prog_q;
    data_d   = data_q;
    pc_d     = pc_q;
    regval_d = regval_q;
    c_d      = c_q;
    halted_d = halted_q;
    icount_d = icount_q;

    if (act) begin
      case (mode_e'(mode))
        LOADPROG: begin
          prog_d[pc_q] = din_x[3:0];
          pc_d         = pc_inc;
        end
        LOADDATA: begin
          data_d[pc_q] = data_in;
          pc_d         = pc_inc;
        end
        SETRUNPT: begin
          pc_d     = din_x[AW-1:0];
          halted_d = 1'b0;
          icount_d = '0;
        end
        RUNPROG: begin
          if (!halted_q) begin
            if (icount_q != '1) icount_d = icount_q + CW'(1);
            if (alu_wr_reg) regval_d = alu_result;
            if (alu_wr_c)   c_d      = alu_carry;
            // A STORE aimed at the current PC lands on this same edge; the
            // operand read this cycle is the old word.
            if (op == OP_STORE) data_d[target] = regval_q;
            if (op == OP_JUMPTOIF) begin
              if (cond_true) begin
                pc_d = target;
                // Taken jump onto itself can never make progress: stop here.
                if (target == pc_q) halted_d = 1'b1;
              end else begin
                pc_d = pc_inc;
              end
            end else begin
              pc_d = pc_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        prog_q[i] <= '0;
        data_q[i] <= '0;
      end
      pc_q     <= '0;
      regval_q <= '0;
      c_q      <= 1'b0;
      halted_q <= 1'b0;
      icount_q <= '0;
    end else begin
      prog_q   <= prog_d;
      data_q   <= data_d;
      pc_q     <= pc_d;
      regval_q <= regval_d;
      c_q      <= c_d;
      halted_q <= halted_d;
      icount_q <= icount_d;
    end
  end

  assign pc     = pc_q;
  assign regval = regval_q;
  assign c_flag = c_q;
  assign z_flag = (regval_q == '0);
  assign halted = halted_q;
  assign icount = icount_q;

endmodule

// File: tb/tb_cpu_core_param.sv
// Testbench for cpu_core_param (DW=4, AW=4, CW=16). Expected architectural
// state {pc, regval, c_flag, z_flag, halted, icount} is queued when stimulus
// is driven and popped for comparison once the DUT has taken the edge.
module tb_cpu_core_param;
  import cpu_core_pkg::*;

  localparam int DW = 4;
  localparam int AW = 4;
  localparam int CW = 16;

  typedef logic [26:0] state_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_step = 1'b0;
  logic          i_run = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] data_in = '0;
  logic          cond_ext = 1'b0;
  logic [1:0]    cond_sel = 2'd0;
  logic [AW-1:0] pc;
  logic [DW-1:0] regval;
  logic          c_flag;
  logic          z_flag;
  logic          halted;
  logic [CW-1:0] icount;

  state_t exp_q[$];
  int     n_vec = 0;
  int     n_bad = 0;

  cpu_core_param #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_step   (i_step),
    .i_run    (i_run),
    .mode     (mode),
    .data_in  (data_in),
    .cond_ext (cond_ext),
    .cond_sel (cond_sel),
    .pc       (pc),
    .regval   (regval),
    .c_flag   (c_flag),
    .z_flag   (z_flag),
    .halted   (halted),
    .icount   (icount)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic state_t mk(int p, int r, bit c, bit h, int ic);
    return {4'(p), 4'(r), c, (4'(r) == 4'd0), h, 16'(ic)};
  endfunction

  function automatic state_t cur();
    return {pc, regval, c_flag, z_flag, halted, icount};
  endfunction

  // One host action; returns 1 time unit after the edge that performs it.
  task automatic act_step(input logic [1:0] m, input logic [3:0] d);
    mode = m; data_in = d; i_step = 1'b1;
    @(posedge clk); #1;
    i_step = 1'b0;
  endtask

  // Write one program word and one data word at address a.
  task automatic setup(input logic [3:0] a, input logic [3:0] op, input logic [3:0] d);
    act_step(SETRUNPT, a);
    act_step(LOADPROG, op);
    act_step(SETRUNPT, a);
    act_step(LOADDATA, d);
  endtask

  task automatic test_reset;
    state_t got, want;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    @(posedge clk); #1;
    got = cur(); want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_bad++; $display("FAIL reset: got state=%h required=%h", got, want);
    end
  endtask

  task automatic test_load_wrap;
    state_t got, want;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 16; i++) begin
        exp_q.push_back(mk((i + 1) % 16, 0, 0, 0, 0));
        act_step(pass == 0 ? LOADPROG : LOADDATA, 4'(i));
        got = cur(); want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin
          n_bad++; $display("FAIL load_wrap[%0d.%0d]: got state=%h required=%h", pass, i, got, want);
        end
      end
    end
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    act_step(SETRUNPT, 4'd0);
    got = cur(); want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_bad++; $display("FAIL setrunpt0: got state=%h required=%h", got, want);
    end
  endtask

  task automatic test_add;
    state_t got, want;
    setup(4'd0, OP_LOAD, 4'd9);
    setup(4'd1, OP_ADD, 4'd8);
    act_step(SETRUNPT, 4'd0);
    exp_q.push_back(mk(1, 9, 0, 0, 1));
    exp_q.push_back(mk(2, 1, 1, 0, 2));
    for (int i = 0; i < 2; i++) begin
      act_step(RUNPROG, 4'd0);
      got = cur(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_bad++; $display("FAIL add[%0d]: got state=%h required=%h", i, got, want);
      end
    end
  endtask

  task automatic test_alu;
    state_t got, want;
    int ops[9], dat[9], er[9];
    bit ec[9];
    ops = '{0, 4, 0, 3, 0, 5, 0, 2, 6};
    dat = '{3, 5, 5, 4, 1, 7, 2, 3, 1};
    er  = '{3, 14, 5, 4, 1, 8, 2, 5, 2};
    ec  = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
    for (int i = 0; i < 9; i++) setup(4'(i), 4'(ops[i]), 4'(dat[i]));
    act_step(SETRUNPT, 4'd0);
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(mk(i + 1, er[i], ec[i], 0, i + 1));
      act_step(RUNPROG, 4'd0);
      got = cur(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_bad++; $display("FAIL alu[%0d] op=%0d: got state=%h required=%h", i, ops[i], got, want);
      end
    end
  endtask

  task automatic test_halt;
    state_t got, want;
    setup(4'd3, OP_JUMPTOIF, 4'd3);
    act_step(SETRUNPT, 4'd3);
    // i_run outside RUNPROG must do nothing.
    mode = LOADPROG; i_run = 1'b1;
    exp_q.push_back(mk(3, 2, 0, 0, 0));
    repeat (2) @(posedge clk); #1;
    got = cur(); want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_bad++; $display("FAIL run_in_loadprog: got state=%h required=%h", got, want);
    end
    cond_sel = COND_ALWAYS; mode = RUNPROG;
    exp_q.push_back(mk(3, 2, 0, 1, 1));
    @(posedge clk); #1;
    got = cur(); want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_bad++; $display("FAIL halt_enter: got state=%h required=%h", got, want);
    end
    exp_q.push_back(mk(3, 2, 0, 1, 1));
    i_step = 1'b1;
    repeat (3) @(posedge clk); #1;
    i_step = 1'b0;
    got = cur(); want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_bad++; $display("FAIL halt_hold: got state=%h required=%h", got, want);
    end
    i_run = 1'b0;
    exp_q.push_back(mk(3, 2, 0, 0, 0));
    act_step(SETRUNPT, 4'd3);
    got = cur(); want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_bad++; $display("FAIL halt_clear: got state=%h required=%h", got, want);
    end
  endtask

  task automatic test_jump_cond;
    state_t got, want;
    cond_sel = COND_Z;
    setup(4'd0, OP_LOAD, 4'd0);
    setup(4'd1, OP_JUMPTOIF, 4'd5);
    act_step(SETRUNPT, 4'd0);
    exp_q.push_back(mk(1, 0, 0, 0, 1));
    exp_q.push_back(mk(5, 0, 0, 0, 2));
    for (int i = 0; i < 2; i++) begin
      act_step(RUNPROG, 4'd0);
      got = cur(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_bad++; $display("FAIL jz_taken[%0d]: got state=%h required=%h", i, got, want);
      end
    end
    setup(4'd0, OP_LOAD, 4'd1);
    act_step(SETRUNPT, 4'd0);
    exp_q.push_back(mk(1, 1, 0, 0, 1));
    exp_q.push_back(mk(2, 1, 0, 0, 2));
    for (int i = 0; i < 2; i++) begin
      act_step(RUNPROG, 4'd0);
      got = cur(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_bad++; $display("FAIL jz_not_taken[%0d]: got state=%h required=%h", i, got, want);
      end
    end
    cond_sel = COND_EXT;
    setup(4'd2, OP_JUMPTOIF, 4'd9);
    for (int e = 1; e >= 0; e--) begin
      cond_ext = e[0];
      act_step(SETRUNPT, 4'd2);
      exp_q.push_back(mk(e ? 9 : 3, 1, 0, 0, 1));
      act_step(RUNPROG, 4'd0);
      got = cur(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_bad++; $display("FAIL jext[%0d]: got state=%h required=%h", e, got, want);
      end
    end
    cond_ext = 1'b0;
  endtask

  task automatic test_store_load;
    state_t got, want;
    setup(4'd0, OP_LOAD, 4'd6);
    setup(4'd1, OP_STORE, 4'd15);
    setup(4'd2, OP_LOAD, 4'd0);
    setup(4'd15, OP_LOAD, 4'd15);
    act_step(SETRUNPT, 4'd0);
    // Step and run together must still execute exactly one instruction.
    exp_q.push_back(mk(1, 6, 0, 0, 1));
    i_run = 1'b1;
    act_step(RUNPROG, 4'd0);
    i_run = 1'b0;
    got = cur(); want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_bad++; $display("FAIL step_and_run: got state=%h required=%h", got, want);
    end
    exp_q.push_back(mk(2, 6, 0, 0, 2));
    exp_q.push_back(mk(3, 0, 0, 0, 3));
    for (int i = 0; i < 2; i++) begin
      act_step(RUNPROG, 4'd0);
      got = cur(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_bad++; $display("FAIL store_seq[%0d]: got state=%h required=%h", i, got, want);
      end
    end
    act_step(SETRUNPT, 4'd15);
    exp_q.push_back(mk(0, 6, 0, 0, 1));
    act_step(RUNPROG, 4'd0);
    got = cur(); want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_bad++; $display("FAIL load_stored: got state=%h required=%h", got, want);
    end
  endtask

  task automatic test_reset_midrun;
    state_t got, want;
    cond_sel = COND_ALWAYS;
    setup(4'd0, OP_ADD, 4'd1);
    setup(4'd1, OP_JUMPTOIF, 4'd0);
    act_step(SETRUNPT, 4'd0);
    // ADD, JUMP, ADD, JUMP, ADD from regval 6.
    exp_q.push_back(mk(1, 9, 0, 0, 5));
    mode = RUNPROG; i_run = 1'b1;
    repeat (5) @(posedge clk); #1;
    got = cur(); want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_bad++; $display("FAIL freerun: got state=%h required=%h", got, want);
    end
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    #2 rst_n = 1'b0;
    #1;
    got = cur(); want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_bad++; $display("FAIL async_reset: got state=%h required=%h", got, want);
    end
    i_run = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    // Cleared memories: word 0 is LOAD of 0, word 1 is LOAD of 0.
    exp_q.push_back(mk(1, 0, 0, 0, 1));
    exp_q.push_back(mk(2, 0, 0, 0, 2));
    for (int i = 0; i < 2; i++) begin
      act_step(RUNPROG, 4'd0);
      got = cur(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_bad++; $display("FAIL mem_cleared[%0d]: got state=%h required=%h", i, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_wrap();
    test_add();
    test_alu();
    test_halt();
    test_jump_cond();
    test_store_load();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
